wb_regfile: RTL
===============

# wb_regfile

Write-back stage and architectural register file for the 5-stage pipeline. Consumes the MEM/WB latch outputs, selects the write-back value (ALU result or loaded data) and commits it to a 32×32-bit register file on the clock edge. Provides the two read ports used by the decode stage, with an optional same-cycle write-to-read bypass. Sits between the MEM/WB latch and the ID/EX latch, closing the pipeline loop.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- reg_write_reg  in  1  write enable from MEM/WB latch
- mem_to_reg_reg  in  1  1 = write data_load_reg, 0 = write alu_result_reg
- alu_result_reg  in  DATA_W  ALU result from MEM/WB latch
- data_load_reg  in  DATA_W  load data from MEM/WB latch
- dst_reg  in  ADDR_W  destination register index
- rs_addr  in  ADDR_W  decode read port A index
- rt_addr  in  ADDR_W  decode read port B index
- rs_data  out  DATA_W  read port A data (combinational)
- rt_data  out  DATA_W  read port B data (combinational)
- wb_data  out  DATA_W  selected write-back value (combinational, for forwarding unit)
- wb_commit  out  1  registered; 1 for one cycle after a write actually committed

## Operation
- wb_data = mem_to_reg_reg ? data_load_reg : alu_result_reg, regardless of reg_write_reg.
- Commit condition: reg_write_reg = 1 and dst_reg != 0 and rst = 0. On rising edge, regs[dst_reg] <= wb_data.
- Register 0: hardwired zero. Writes to index 0 are discarded, no wb_commit; reads of index 0 return 0 in all modes.
- Reads: rs_data = regs[rs_addr], rt_data = regs[rt_addr], asynchronous. Both ports may address the same register.
- wb_commit <= commit condition, registered.
- Reset: all 32 registers cleared to 0, wb_commit <= 0. Reset has priority over a simultaneous write; a write presented in the reset cycle is lost.
- Reset mid-operation: state after the reset edge is identical to power-on reset; no partial writes.
- Unknown/X on dst_reg while reg_write_reg = 0 must not corrupt any register.

## Timing
- Write latency: value on MEM/WB outputs at edge N is stored at edge N; visible on read ports without bypass after edge N (cycle N+1).
- Read latency: 0 cycles (combinational from rs_addr/rt_addr and register state).
- wb_commit asserted during cycle N+1 for a commit at edge N, exactly one cycle per commit; back-to-back commits keep it high.
- After rst deasserted at edge R, first write can commit at edge R+1.
- Reset values: rs_data = rt_data = 0 (every register zero), wb_commit = 0, wb_data follows inputs.

## Configuration
- WB_BYPASS_EN defined: if commit condition holds (ignoring rst gating is NOT allowed: rst = 1 disables bypass) and rs_addr == dst_reg (resp. rt_addr), rs_data (rt_data) returns wb_data in the same cycle, emulating write-first-half/read-second-half. Index 0 never bypassed.
- WB_BYPASS_EN undefined: read ports return stored contents only; same-cycle read of the register being written returns the old value.

## Test plan
- Reset: drive rst = 1 for 2 cycles after writing 0xDEADBEEF to r5 -> rs_addr = 5 reads 0, wb_commit = 0.
- ALU write: reg_write_reg = 1, mem_to_reg_reg = 0, alu_result_reg = 0x00000011, data_load_reg = 0x00000022, dst_reg = 3 -> after edge rs_addr = 3 reads 0x11, wb_commit = 1 one cycle.
- Load write: same stimulus with mem_to_reg_reg = 1, dst_reg = 4 -> rt_addr = 4 reads 0x22; then reg_write_reg = 0, dst_reg = 4, data 0xFFFFFFFF -> r4 still 0x22, wb_commit = 0.
- Zero register: write 0x12345678 to dst_reg = 0 -> rs_addr = 0 reads 0, wb_commit = 0.
- Same-cycle read: write 0xCAFEF00D to r7 with rs_addr = rt_addr = 7 before edge -> with WB_BYPASS_EN both read 0xCAFEF00D before edge; without, both read previous 0 until after edge.
- Reset vs write: rst = 1 and write 0xA5A5A5A5 to r9 same cycle -> r9 reads 0 after edge, wb_commit = 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back select and 32-entry register file; optional same-cycle bypass under WB_BYPASS_EN.
// Latency: reads combinational, write commits on the clock edge, wb_commit one cycle later.
// Backpressure: none; every MEM/WB beat is consumed each cycle.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_reg,
    input  logic              mem_to_reg_reg,
    input  logic [DATA_W-1:0] alu_result_reg,
    input  logic [DATA_W-1:0] data_load_reg,
    input  logic [ADDR_W-1:0] dst_reg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_commit
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              commit;

    assign wb_data = mem_to_reg_reg ? data_load_reg : alu_result_reg;
    // Reset gates the commit so a write presented during reset is dropped.
    assign commit  = reg_write_reg && (dst_reg != '0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_commit <= 1'b0;
        end else begin
            wb_commit <= commit;
            if (commit) begin
                regs[dst_reg] <= wb_data;
            end
        end
    end

    always_comb begin
        rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
        rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef WB_BYPASS_EN
        // commit already excludes index 0, so r0 is never bypassed.
        if (commit && (rs_addr == dst_reg)) begin
            rs_data = wb_data;
        end
        if (commit && (rt_addr == dst_reg)) begin
            rt_data = wb_data;
        end
`endif
    end
endmodule
